// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller with per-slot dead time and frame-synchronous value update.
// Optional LEAD_ZERO_BLANK_EN: suppress leading zero digits (digit 0 always shown).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [4*NUM_DIGITS-1:0]       value_i,
    input  logic                          load_i,
    output logic [3:0]                    bcd_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
    output logic                          frame_o
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;
    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d, disp_q, disp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [3:0]              bcd_d;
    logic                    frame_d, show;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    frame_d = 1'b1;
                end
                BLANK: begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CW'(BLANK_CYCLES - 1)) ? SHOW : BLANK;
                end
                SHOW: begin
                    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
                        frame_d = (idx_q == IW'(NUM_DIGITS - 1));
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // Pending value becomes visible at the same edge frame_o rises, so digit 0 of the new frame already shows it.
    assign disp_d     = (frame_d && pend_vld_q) ? pend_q : disp_q;
    assign pend_d     = load_i ? value_i : pend_q;
    assign pend_vld_d = load_i | (pend_vld_q & ~frame_d);
`ifdef LEAD_ZERO_BLANK_EN
    logic [IW-1:0] msd;
    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (disp_d[4*i +: 4] != 4'h0) msd = IW'(i);
    end
    assign show = (state_d == SHOW) && (idx_d <= msd);
`else
    assign show = (state_d == SHOW);
`endif
    assign bcd_d = (state_d == IDLE) ? 4'h0 : disp_d[4*idx_d +: 4];
    assign an_d  = show ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            disp_q      <= '0;
            pend_vld_q  <= 1'b0;
            an_o        <= '1;
            bcd_o       <= 4'h0;
            digit_idx_o <= '0;
            frame_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            disp_q      <= disp_d;
            pend_vld_q  <= pend_vld_d;
            an_o        <= an_d;
            bcd_o       <= bcd_d;
            digit_idx_o <= idx_d;
            frame_o     <= frame_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random stimulus against a time-based reference model of the scan.
module tb_seg_scan_ctrl;
    localparam int ND = 4, RD = 8, BC = 2, FP = ND * RD;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  bcd, an;
    logic [1:0]  idx;
    logic        frame;
    int          tests = 0, fails = 0;
    bit          act = 0, pvld = 0;
    int          t = 0;
    logic [15:0] pend = '0, disp = '0;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .value_i(value), .load_i(load),
        .bcd_o(bcd), .an_o(an), .digit_idx_o(idx), .frame_o(frame));

    always #5 clk = ~clk;

    function automatic int msd_of(logic [15:0] d);
        int m = 0;
        for (int i = 1; i < ND; i++) if (d[4*i +: 4] != 4'h0) m = i;
        return m;
    endfunction

    task automatic check();
        int slot, pos;
        bit shown;
        logic [3:0] one, e_an, e_bcd;
        logic [1:0] e_idx;
        logic e_frame;
        one = 4'b0001;
        slot = (t / RD) % ND;
        pos = t % RD;
        shown = act && pos >= BC;
`ifdef LEAD_ZERO_BLANK_EN
        shown = shown && slot <= msd_of(disp);
`endif
        e_an = shown ? ~(one << slot) : 4'hf;
        e_bcd = act ? disp[4*slot +: 4] : 4'h0;
        e_idx = act ? 2'(slot) : 2'd0;
        e_frame = act && (t % FP == 0);
        tests += 5;
        assert (an === e_an) else begin fails++; $error("FAIL an t=%0d got %b expected %b", t, an, e_an); end
        assert (bcd === e_bcd) else begin fails++; $error("FAIL bcd t=%0d got %h expected %h", t, bcd, e_bcd); end
        assert (idx === e_idx) else begin fails++; $error("FAIL idx t=%0d got %0d expected %0d", t, idx, e_idx); end
        assert (frame === e_frame) else begin fails++; $error("FAIL frame t=%0d got %b expected %b", t, frame, e_frame); end
        assert (($countones(~an) <= 1) === 1'b1) else begin fails++; $error("FAIL one_hot an=%b expected at most one low", an); end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            act = 0; t = 0; pend = '0; disp = '0; pvld = 0;
        end else begin
            if (!en) begin act = 0; t = 0; end
            else if (!act) begin act = 1; t = 0; end
            else t++;
            if (act && t % FP == 0 && pvld) begin disp = pend; pvld = 0; end
            if (load) begin pend = value; pvld = 1; end
        end
        @(negedge clk);
        check();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic do_load(logic [15:0] v);
        value = v; load = 1'b1; step(); load = 1'b0;
    endtask

    task automatic seek(int slot, int pos);
        for (int i = 0; i < 200 && !(act && (t / RD) % ND == slot && t % RD == pos); i++) step();
    endtask

    initial begin
        @(negedge clk);
        run(2);
        rst = 1'b0;
        step();
        en = 1'b1;
        run(70);
        do_load(16'h1234);
        run(70);
        do_load(16'h1111);
        run(3);
        do_load(16'h2222);
        seek(0, 0);
        do_load(16'h3333);
        run(70);
        seek(2, 4);
        en = 1'b0;
        step();
        en = 1'b1;
        run(40);
        do_load(16'hABCD);
        run(40);
        seek(1, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(40);
        do_load(16'h0050);
        run(70);
        do_load(16'h0000);
        run(70);
        repeat (3000) begin
            en = ($urandom_range(0, 99) != 0);
            load = ($urandom_range(0, 19) == 0);
            value = 16'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0; en = 1'b1;
        run(40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
